// File: rtl/stream_video_pattern_gen.sv
// stream_video_pattern_gen: AXI4-Stream video test-pattern source.
// Emits FRAME_W x FRAME_H beat frames with SOF on tuser and EOL on tlast.
// Define VPG_LFSR_EN to build the pseudo-random pattern (mode 3); when it is
// undefined, no LFSR logic exists and mode 3 produces the ramp pattern.
module stream_video_pattern_gen #(
    parameter int unsigned CH_W       = 8,
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned FRAME_W    = 20,
    parameter int unsigned FRAME_H    = 10,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [1:0]               mode,
    output logic [CH_W*CHANNELS-1:0] m_axis_video_tdata,
    output logic                     m_axis_video_tvalid,
    input  logic                     m_axis_video_tready,
    output logic                     m_axis_video_tuser,
    output logic                     m_axis_video_tlast,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int unsigned DATA_W = CH_W * CHANNELS;
    localparam int unsigned XW     = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int unsigned YW     = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int unsigned GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Elaboration-time parameter sanity checks.
    if (DATA_W > 32) begin : g_bad_width
        $error("stream_video_pattern_gen: CH_W*CHANNELS must be <= 32");
    end
    if (LFSR_SEED == 32'd0) begin : g_bad_seed
        $error("stream_video_pattern_gen: LFSR_SEED must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_valid, w_valid_nxt;
    logic [DATA_W-1:0]   r_tdata, w_tdata_nxt;
    logic                r_tuser, w_tuser_nxt;
    logic                r_tlast, w_tlast_nxt;
    logic [XW-1:0]       r_x, w_x_nxt;
    logic [YW-1:0]       r_y, w_y_nxt;
    logic [1:0]          r_mode, w_mode_nxt;
    logic [GW-1:0]       r_gap, w_gap_nxt;
    logic                r_done, w_done_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                w_load;
    logic                w_xfer;
    logic                w_last_x;
    logic                w_last_y;

`ifdef VPG_LFSR_EN
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    logic [31:0] r_lfsr, w_lfsr_nxt, w_lfsr_adv;

    // Galois LFSR one step ahead, consumed only when a beat transfers.
    assign w_lfsr_adv = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);
`endif

    // Deterministic patterns (ramp, bars, grey) for one pixel position.
    function automatic logic [DATA_W-1:0] f_pattern(
        input logic [1:0]    md,
        input logic [XW-1:0] px,
        input logic [YW-1:0] py
    );
        logic [DATA_W-1:0] v;
        logic [CH_W-1:0]   ch;
        logic [31:0]       bar;
        v   = '0;
        bar = (32'(px) << 3) / 32'(FRAME_W);
        for (int c = 0; c < int'(CHANNELS); c++) begin
            case (md)
                2'd1:    ch = (((bar >> (c % 3)) & 32'd1) != 32'd0) ? '1 : '0;
                2'd2:    ch = CH_W'(1) << (CH_W - 1);
                default: ch = CH_W'(px) + CH_W'(py) + CH_W'(c);
            endcase
            v = v | (DATA_W'(ch) << (c * int'(CH_W)));
        end
        return v;
    endfunction

    assign w_xfer   = r_valid && m_axis_video_tready;
    assign w_last_x = (r_x == XW'(FRAME_W - 1));
    assign w_last_y = (r_y == YW'(FRAME_H - 1));

    // Next-state and next-output logic; everything holds unless a branch moves it.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_tdata_nxt = r_tdata;
        w_tuser_nxt = r_tuser;
        w_tlast_nxt = r_tlast;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_mode_nxt  = r_mode;
        w_gap_nxt   = r_gap;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
`ifdef VPG_LFSR_EN
        w_lfsr_nxt  = r_lfsr;
`endif

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_mode_nxt  = mode;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
`ifdef VPG_LFSR_EN
                    w_lfsr_nxt = w_lfsr_adv;
`endif
                    if (!w_last_x) begin
                        w_x_nxt = r_x + XW'(1);
                        w_load  = 1'b1;
                    end else if (!w_last_y) begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + YW'(1);
                        w_load  = 1'b1;
                    end else begin
                        // Last beat of the frame has gone out.
                        w_done_nxt = 1'b1;
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                        w_x_nxt    = '0;
                        w_y_nxt    = '0;
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = GW'(GAP_CYCLES - 1);
                            w_valid_nxt = 1'b0;
                        end else if (enable) begin
                            w_mode_nxt = mode;
                            w_load     = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_valid_nxt = 1'b0;
                        end
                        if (!w_load) begin
                            w_tdata_nxt = '0;
                            w_tuser_nxt = 1'b0;
                            w_tlast_nxt = 1'b0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    if (enable) begin
                        w_state_nxt = S_RUN;
                        w_mode_nxt  = mode;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        // Present the beat at (w_x_nxt, w_y_nxt) on the next cycle.
        if (w_load) begin
            w_state_nxt = S_RUN;
            w_valid_nxt = 1'b1;
            w_tdata_nxt = f_pattern(w_mode_nxt, w_x_nxt, w_y_nxt);
`ifdef VPG_LFSR_EN
            if (w_mode_nxt == 2'd3) begin
                w_tdata_nxt = w_lfsr_nxt[DATA_W-1:0];
            end
`endif
            w_tuser_nxt = (w_x_nxt == '0) && (w_y_nxt == '0);
            w_tlast_nxt = (w_x_nxt == XW'(FRAME_W - 1));
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_tdata <= '0;
            r_tuser <= 1'b0;
            r_tlast <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_mode  <= 2'd0;
            r_gap   <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
`ifdef VPG_LFSR_EN
            r_lfsr  <= LFSR_SEED;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_tdata <= w_tdata_nxt;
            r_tuser <= w_tuser_nxt;
            r_tlast <= w_tlast_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_mode  <= w_mode_nxt;
            r_gap   <= w_gap_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef VPG_LFSR_EN
            r_lfsr  <= w_lfsr_nxt;
`endif
        end
    end

    assign m_axis_video_tdata  = r_tdata;
    assign m_axis_video_tvalid = r_valid;
    assign m_axis_video_tuser  = r_tuser;
    assign m_axis_video_tlast  = r_tlast;
    assign frame_done          = r_done;
    assign frame_cnt           = r_cnt;

endmodule

// File: tb/tb_stream_video_pattern_gen.sv
// Testbench for stream_video_pattern_gen: scoreboard of expected beats built
// from the pattern rules, checked by monitors on the default 20x10 instance
// and on a small instance with inter-frame gaps.
module tb_stream_video_pattern_gen;

    localparam int FW   = 20;
    localparam int FH   = 10;
    localparam int GFW  = 4;
    localparam int GFH  = 2;
    localparam int GGAP = 4;

    typedef struct packed {
        logic [23:0] data;
        logic        user;
        logic        last;
        logic        eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        tready = 1'b1;
    logic [23:0] tdata;
    logic        tvalid, tuser, tlast, fdone;
    logic [15:0] fcnt;

    logic        g_enable = 1'b0;
    logic [23:0] g_tdata;
    logic        g_tvalid, g_tuser, g_tlast, g_done;
    logic [15:0] g_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ready = 1'b0;

    beat_t exp_q[$];
    int    mon_beats = 0;
    int    mon_users = 0;
    int    mon_lasts = 0;
    int    exp_frames = 0;
    bit    pend_done = 1'b0;
    bit    prev_stall = 1'b0;
    logic [23:0] st_data;
    logic        st_user, st_last;

    int gx = 0, gy = 0, g_gap = 0, g_frames = 0, g_meas = 0;
    bit g_measuring = 1'b0, g_pend = 1'b0;

`ifdef VPG_LFSR_EN
    logic [31:0] model_lfsr = 32'hACE1;
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction
`endif

    always #5 clk = ~clk;

    stream_video_pattern_gen dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .mode                (mode),
        .m_axis_video_tdata  (tdata),
        .m_axis_video_tvalid (tvalid),
        .m_axis_video_tready (tready),
        .m_axis_video_tuser  (tuser),
        .m_axis_video_tlast  (tlast),
        .frame_done          (fdone),
        .frame_cnt           (fcnt)
    );

    stream_video_pattern_gen #(
        .FRAME_W    (GFW),
        .FRAME_H    (GFH),
        .GAP_CYCLES (GGAP)
    ) u_gap (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (g_enable),
        .mode                (2'd0),
        .m_axis_video_tdata  (g_tdata),
        .m_axis_video_tvalid (g_tvalid),
        .m_axis_video_tready (1'b1),
        .m_axis_video_tuser  (g_tuser),
        .m_axis_video_tlast  (g_tlast),
        .frame_done          (g_done),
        .frame_cnt           (g_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference pixel from the pattern rules (8-bit channels, 3 channels).
    function automatic logic [23:0] model_pix(input int md, input int x, input int y, input int fw);
        logic [23:0] p;
        int bar, v;
        p   = '0;
        bar = (x * 8) / fw;
        for (int c = 0; c < 3; c++) begin
            if (md == 1)      v = (((bar >> (c % 3)) & 1) != 0) ? 255 : 0;
            else if (md == 2) v = 128;
            else              v = (x + y + c) % 256;
            p = p | (24'(v) << (8 * c));
        end
        return p;
    endfunction

    task automatic push_frame(input int md);
        beat_t b;
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                b.data = model_pix(md, x, y, FW);
`ifdef VPG_LFSR_EN
                if (md == 3) b.data = model_lfsr[23:0];
                model_lfsr = lfsr_step(model_lfsr);
`endif
                b.user = (x == 0) && (y == 0);
                b.last = (x == FW - 1);
                b.eof  = (x == FW - 1) && (y == FH - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Returns on a posedge once the monitor has seen 'target' transfers.
    task automatic wait_beats(input int target, input string what);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (mon_beats < target && t < 3000);
        if (mon_beats < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s: beats %0d required %0d", what, mon_beats, target);
        end
    endtask

    task automatic idle_check(input string what);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({what, "_idle_valid"}, 32'(tvalid), 32'd0);
        end
        check({what, "_queue_empty"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic first_beat(input string what, input logic [23:0] expd);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!tvalid && t < 50);
        check({what, "_first_valid"}, 32'(tvalid), 32'd1);
        check({what, "_first_data"}, 32'(tdata), 32'(expd));
        check({what, "_first_user"}, 32'(tuser), 32'd1);
    endtask

    task automatic run_frame(input int md, input int drop_at, input string what);
        int base;
        base = mon_beats;
        push_frame(md);
        mode   = 2'(md);
        enable = 1'b1;
        wait_beats(base + drop_at, what);
        #1;
        enable = 1'b0;
        mode   = 2'($urandom_range(0, 3));
        wait_beats(base + FW * FH, what);
        #1;
        idle_check(what);
    endtask

    // Sink ready: full rate or 50% random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Main monitor: pops the scoreboard on each transfer, checks stalls and frame_done.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            pend_done  = 1'b0;
            prev_stall = 1'b0;
            exp_frames = 0;
        end else begin
            if (pend_done) begin
                exp_frames++;
                check("frame_done_pulse", 32'(fdone), 32'd1);
                check("frame_cnt", 32'(fcnt), 32'(exp_frames));
                pend_done = 1'b0;
            end else begin
                check("frame_done_quiet", 32'(fdone), 32'd0);
            end
            if (prev_stall) begin
                check("stall_valid", 32'(tvalid), 32'd1);
                check("stall_data", 32'(tdata), 32'(st_data));
                check("stall_user", 32'(tuser), 32'(st_user));
                check("stall_last", 32'(tlast), 32'(st_last));
            end
            prev_stall = tvalid && !tready;
            st_data    = tdata;
            st_user    = tuser;
            st_last    = tlast;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h with no beat expected", tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(tdata), 32'(e.data));
                    check("beat_user", 32'(tuser), 32'(e.user));
                    check("beat_last", 32'(tlast), 32'(e.last));
                    if (e.eof) pend_done = 1'b1;
                end
                mon_beats++;
                if (tuser) mon_users++;
                if (tlast) mon_lasts++;
            end
        end
    end

    // Gap-instance monitor: ramp content, gap length and frame_done timing.
    always @(negedge clk) begin
        if (!rst) begin
            gx = 0; gy = 0; g_gap = 0; g_frames = 0;
            g_measuring = 1'b0; g_pend = 1'b0;
        end else begin
            if (g_pend) begin
                g_frames++;
                check("gap_frame_done", 32'(g_done), 32'd1);
                check("gap_frame_cnt", 32'(g_cnt), 32'(g_frames));
                g_pend = 1'b0;
            end else begin
                check("gap_frame_done_quiet", 32'(g_done), 32'd0);
            end
            if (g_tvalid) begin
                if (g_measuring) begin
                    check("gap_len", 32'(g_gap), 32'(GGAP));
                    g_measuring = 1'b0;
                    g_meas++;
                end
                check("gap_data", 32'(g_tdata), 32'(model_pix(0, gx, gy, GFW)));
                check("gap_user", 32'(g_tuser), 32'((gx == 0) && (gy == 0)));
                check("gap_last", 32'(g_tlast), 32'(gx == GFW - 1));
                if (gx == GFW - 1) begin
                    gx = 0;
                    if (gy == GFH - 1) begin
                        gy = 0;
                        g_pend = 1'b1;
                        g_measuring = 1'b1;
                        g_gap = 0;
                    end else begin
                        gy++;
                    end
                end else begin
                    gx++;
                end
            end else if (g_measuring) begin
                g_gap++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, u0, l0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(tvalid), 32'd0);
        check("reset_data", 32'(tdata), 32'd0);
        check("reset_user", 32'(tuser), 32'd0);
        check("reset_last", 32'(tlast), 32'd0);
        check("reset_done", 32'(fdone), 32'd0);
        check("reset_cnt", 32'(fcnt), 32'd0);
        rst = 1'b1;
        g_enable = 1'b1;

        // One full-rate ramp frame.
        base = mon_beats;
        u0 = mon_users;
        l0 = mon_lasts;
        push_frame(0);
        mode = 2'd0;
        enable = 1'b1;
        first_beat("t1", 24'h020100);
        wait_beats(base + 1, "t1_sof");
        #1;
        enable = 1'b0;
        wait_beats(base + FW * FH, "t1_end");
        #1;
        idle_check("t1");
        check("t1_user_count", 32'(mon_users - u0), 32'd1);
        check("t1_last_count", 32'(mon_lasts - l0), 32'd10);
        check("t1_frame_cnt", 32'(fcnt), 32'd1);

        // Random backpressure, enable dropped at beat 57.
        rand_ready = 1'b1;
        run_frame(0, 57, "t2");
        check("t2_frame_cnt", 32'(fcnt), 32'd2);

        // Mode change mid-frame, back-to-back second frame.
        base = mon_beats;
        push_frame(0);
        mode = 2'd0;
        enable = 1'b1;
        wait_beats(base + 30, "t4_mid");
        #1;
        mode = 2'd1;
        push_frame(1);
        wait_beats(base + FW * FH + 1, "t4_sof2");
        #1;
        enable = 1'b0;
        mode = 2'd2;
        wait_beats(base + 2 * FW * FH, "t4_end");
        #1;
        idle_check("t4");

        // Randomised frames.
        for (int i = 0; i < 4; i++) begin
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 199)), "rnd");
        end

        // Reset in the middle of a frame.
        base = mon_beats;
        push_frame(0);
        mode = 2'd0;
        enable = 1'b1;
        wait_beats(base + 100, "t6_mid");
        #1;
        rst = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("t6_valid", 32'(tvalid), 32'd0);
        check("t6_cnt", 32'(fcnt), 32'd0);
        check("t6_done", 32'(fdone), 32'd0);
        check("t6_user", 32'(tuser), 32'd0);
        exp_q.delete();
`ifdef VPG_LFSR_EN
        model_lfsr = 32'hACE1;
`endif
        rst = 1'b1;
        base = mon_beats;
        push_frame(3);
        mode = 2'd3;
        enable = 1'b1;
`ifdef VPG_LFSR_EN
        first_beat("t6", 24'h00ACE1);
`else
        first_beat("t6", 24'h020100);
`endif
        wait_beats(base + 1, "t6_sof");
        #1;
        enable = 1'b0;
        wait_beats(base + FW * FH, "t6_end");
        #1;
        idle_check("t6");
        check("t6_frame_cnt", 32'(fcnt), 32'd1);

        check("gap_measured", 32'(g_meas > 0), 32'd1);
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
